// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: memory-control bit positions,
// FSM encoding, exception codes, bus size codes and load kinds.
package mem_pkg;

   localparam int MEM_CTL_W = 8;
   typedef logic [MEM_CTL_W-1:0] mem_ctl_t;

   localparam int CTL_LB  = 0;
   localparam int CTL_LBU = 1;
   localparam int CTL_LH  = 2;
   localparam int CTL_LHU = 3;
   localparam int CTL_LW  = 4;
   localparam int CTL_SB  = 5;
   localparam int CTL_SH  = 6;
   localparam int CTL_SW  = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [2:0] {
      LD_B  = 3'd0,
      LD_BU = 3'd1,
      LD_H  = 3'd2,
      LD_HU = 3'd3,
      LD_W  = 3'd4
   } load_e;

   function automatic logic is_onehot(input mem_ctl_t c);
      return (c != '0) && ((c & (c - mem_ctl_t'(1))) == '0);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half/word lane of load data and sign- or
// zero-extends it to 32 bits.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  load_e       load_type,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      byte_lane = rdata[7:0];
      case (addr_lo)
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         2'd3:    byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      result = rdata;
      case (load_type)
         LD_B:    result = {{24{byte_lane[7]}}, byte_lane};
         LD_BU:   result = {24'h0, byte_lane};
         LD_H:    result = {{16{half_lane[15]}}, half_lane};
         LD_HU:   result = {16'h0, half_lane};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues loads/stores on an SRAM-like bus with an IDLE/REQ/RESP
// handshake FSM and registers the result for forwarding and writeback.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter bit KSEG_MAP = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_mem_control,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_store_data,
   input  logic [4:0]  in_rn,
   input  logic        in_write_regfile,
   input  logic        in_mem_to_regfile,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [31:0] data_sram_addr,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic        mem_valid,
   output logic [31:0] mem_data,
   output logic [4:0]  mem_reg,
   output logic        mem_write_regfile,
   output logic        mem_mem_to_regfile,
   output logic        mem_excp,
   output logic [4:0]  mem_excode,
   output logic [31:0] mem_badvaddr
);

   state_e      state_q, state_d;
   mem_ctl_t    lat_ctl;
   logic [31:0] lat_addr, lat_sdata;
   logic [4:0]  lat_rn;
   logic        lat_wrf, lat_m2r;

   logic        ctl_onehot, misaligned, is_load, accept, mem_op_ok;
   logic        lat_is_load;
   load_e       lat_load_type;
   logic [31:0] load_result;

   assign ctl_onehot = is_onehot(in_mem_control);
   assign is_load    = |in_mem_control[CTL_LW:CTL_LB];
   assign misaligned = ((in_mem_control[CTL_LH] | in_mem_control[CTL_LHU] | in_mem_control[CTL_SH])
                        & in_addr[0])
                     | ((in_mem_control[CTL_LW] | in_mem_control[CTL_SW]) & (in_addr[1:0] != 2'b00));
   assign mem_op_ok  = ctl_onehot & ~misaligned;
   assign accept     = (state_q == IDLE) & in_valid;

   assign in_ready      = (state_q == IDLE);
   assign data_sram_req = (state_q == REQ);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid && mem_op_ok) state_d = REQ;
         REQ:     if (data_sram_addr_ok) state_d = RESP;
         RESP:    if (data_sram_data_ok) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request fields are captured on accept so the bus stays stable while stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_ctl   <= '0;
         lat_addr  <= '0;
         lat_sdata <= '0;
         lat_rn    <= '0;
         lat_wrf   <= 1'b0;
         lat_m2r   <= 1'b0;
      end else if (accept && mem_op_ok) begin
         lat_ctl   <= in_mem_control;
         lat_addr  <= in_addr;
         lat_sdata <= in_store_data;
         lat_rn    <= in_rn;
         lat_wrf   <= in_write_regfile;
         lat_m2r   <= in_mem_to_regfile;
      end
   end

   always_comb begin
      data_sram_addr = lat_addr;
      if (KSEG_MAP && lat_addr[31:30] == 2'b10) data_sram_addr = {3'b000, lat_addr[28:0]};
   end

   always_comb begin
      data_sram_wr    = 1'b0;
      data_sram_size  = SIZE_BYTE;
      data_sram_wstrb = 4'b0000;
      data_sram_wdata = lat_sdata;
      if (lat_ctl[CTL_LH] | lat_ctl[CTL_LHU] | lat_ctl[CTL_SH]) data_sram_size = SIZE_HALF;
      if (lat_ctl[CTL_LW] | lat_ctl[CTL_SW])                    data_sram_size = SIZE_WORD;
      if (lat_ctl[CTL_SB]) begin
         data_sram_wr    = 1'b1;
         data_sram_wstrb = 4'b0001 << lat_addr[1:0];
         data_sram_wdata = {4{lat_sdata[7:0]}};
      end else if (lat_ctl[CTL_SH]) begin
         data_sram_wr    = 1'b1;
         data_sram_wstrb = lat_addr[1] ? 4'b1100 : 4'b0011;
         data_sram_wdata = {2{lat_sdata[15:0]}};
      end else if (lat_ctl[CTL_SW]) begin
         data_sram_wr    = 1'b1;
         data_sram_wstrb = 4'b1111;
      end
   end

   assign lat_is_load = |lat_ctl[CTL_LW:CTL_LB];

   always_comb begin
      lat_load_type = LD_W;
      if      (lat_ctl[CTL_LB])  lat_load_type = LD_B;
      else if (lat_ctl[CTL_LBU]) lat_load_type = LD_BU;
      else if (lat_ctl[CTL_LH])  lat_load_type = LD_H;
      else if (lat_ctl[CTL_LHU]) lat_load_type = LD_HU;
   end

   mem_load_align u_load_align (
      .rdata     (data_sram_rdata),
      .addr_lo   (lat_addr[1:0]),
      .load_type (lat_load_type),
      .result    (load_result)
   );

   // Result register: pass-through and exceptions complete from IDLE, bus ops from RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_valid          <= 1'b0;
         mem_data           <= '0;
         mem_reg            <= '0;
         mem_write_regfile  <= 1'b0;
         mem_mem_to_regfile <= 1'b0;
         mem_excp           <= 1'b0;
         mem_excode         <= '0;
         mem_badvaddr       <= '0;
      end else begin
         mem_valid <= 1'b0;
         if (accept && !mem_op_ok) begin
            mem_valid          <= 1'b1;
            mem_data           <= in_addr;
            mem_reg            <= in_rn;
            mem_mem_to_regfile <= in_mem_to_regfile;
            if (ctl_onehot) begin
               mem_write_regfile <= 1'b0;
               mem_excp          <= 1'b1;
               mem_excode        <= is_load ? EXC_ADEL : EXC_ADES;
               mem_badvaddr      <= in_addr;
            end else begin
               mem_write_regfile <= in_write_regfile;
               mem_excp          <= 1'b0;
               mem_excode        <= '0;
            end
         end else if (state_q == RESP && data_sram_data_ok) begin
            mem_valid          <= 1'b1;
            mem_data           <= lat_is_load ? load_result : lat_addr;
            mem_reg            <= lat_rn;
            mem_write_regfile  <= lat_wrf;
            mem_mem_to_regfile <= lat_m2r;
            mem_excp           <= 1'b0;
            mem_excode         <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; the bench plays the SRAM
// bus and checks results against hand-computed values.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_mem_control;
   logic [31:0] in_addr, in_store_data;
   logic [4:0]  in_rn;
   logic        in_write_regfile, in_mem_to_regfile;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
   logic [3:0]  data_sram_wstrb;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic        mem_valid;
   logic [31:0] mem_data, mem_badvaddr;
   logic [4:0]  mem_reg, mem_excode;
   logic        mem_write_regfile, mem_mem_to_regfile, mem_excp;

   int total = 0;
   int bad   = 0;

   // observations captured by bus_op
   logic        req_first, req_after, stable, rdy_low, early_valid;
   logic [31:0] snap_addr, snap_wdata;
   logic [1:0]  snap_size;
   logic [3:0]  snap_wstrb;
   logic        snap_wr;

   always #5 clk = ~clk;

   mem_access_unit #(.KSEG_MAP(1'b1)) dut (
      .clk                (clk),
      .reset              (reset),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_mem_control     (in_mem_control),
      .in_addr            (in_addr),
      .in_store_data      (in_store_data),
      .in_rn              (in_rn),
      .in_write_regfile   (in_write_regfile),
      .in_mem_to_regfile  (in_mem_to_regfile),
      .data_sram_req      (data_sram_req),
      .data_sram_wr       (data_sram_wr),
      .data_sram_size     (data_sram_size),
      .data_sram_addr     (data_sram_addr),
      .data_sram_wstrb    (data_sram_wstrb),
      .data_sram_wdata    (data_sram_wdata),
      .data_sram_addr_ok  (data_sram_addr_ok),
      .data_sram_data_ok  (data_sram_data_ok),
      .data_sram_rdata    (data_sram_rdata),
      .mem_valid          (mem_valid),
      .mem_data           (mem_data),
      .mem_reg            (mem_reg),
      .mem_write_regfile  (mem_write_regfile),
      .mem_mem_to_regfile (mem_mem_to_regfile),
      .mem_excp           (mem_excp),
      .mem_excode         (mem_excode),
      .mem_badvaddr       (mem_badvaddr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] ctl, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rn, input logic wrf, input logic m2r);
      in_valid          = 1'b1;
      in_mem_control    = ctl;
      in_addr           = addr;
      in_store_data     = sdata;
      in_rn             = rn;
      in_write_regfile  = wrf;
      in_mem_to_regfile = m2r;
   endtask

   // Accept at T, hold addr_ok off for aok_delay cycles, data_ok one cycle after addr_ok.
   // Returns with time positioned in the cycle where mem_valid is expected.
   task automatic bus_op(input logic [7:0] ctl, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rn, input logic wrf, input logic m2r,
                         input int aok_delay, input logic [31:0] rdata);
      drive(ctl, addr, sdata, rn, wrf, m2r);
      tick();
      in_valid    = 1'b0;
      req_first   = data_sram_req;
      snap_addr   = data_sram_addr;
      snap_size   = data_sram_size;
      snap_wstrb  = data_sram_wstrb;
      snap_wdata  = data_sram_wdata;
      snap_wr     = data_sram_wr;
      stable      = 1'b1;
      rdy_low     = !in_ready;
      early_valid = mem_valid;
      for (int i = 0; i < aok_delay; i++) begin
         tick();
         if (data_sram_req !== 1'b1 || data_sram_addr !== snap_addr || data_sram_size !== snap_size ||
             data_sram_wstrb !== snap_wstrb || data_sram_wdata !== snap_wdata || data_sram_wr !== snap_wr)
            stable = 1'b0;
         if (in_ready !== 1'b0) rdy_low = 1'b0;
         if (mem_valid !== 1'b0) early_valid = 1'b1;
      end
      data_sram_addr_ok = 1'b1;
      tick();
      data_sram_addr_ok = 1'b0;
      req_after = data_sram_req;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      if (mem_valid !== 1'b0) early_valid = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rdata;
      tick();
      data_sram_data_ok = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b0; in_mem_control = '0; in_addr = '0; in_store_data = '0;
      in_rn = '0; in_write_regfile = 1'b0; in_mem_to_regfile = 1'b0;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
      tick(); tick();
      reset = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (data_sram_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", data_sram_req); end
      total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
      total++; if (mem_data !== 32'h0) begin bad++; $display("FAIL reset_mem_data got=%h exp=0", mem_data); end
      total++; if ({mem_reg, mem_write_regfile, mem_mem_to_regfile, mem_excp, mem_excode} !== 13'h0) begin
         bad++; $display("FAIL reset_mem_fields got=%h exp=0", {mem_reg, mem_write_regfile, mem_mem_to_regfile, mem_excp, mem_excode}); end
      total++; if ({data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr} !== 39'h0) begin
         bad++; $display("FAIL reset_bus got=%h exp=0", {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr}); end
   endtask

   task automatic test_lw_kseg();
      bus_op(8'h10, 32'h8000_0010, 32'h0, 5'd3, 1'b1, 1'b1, 0, 32'hDEAD_BEEF);
      total++; if (req_first !== 1'b1) begin bad++; $display("FAIL lw_req_t1 got=%b exp=1", req_first); end
      total++; if (snap_addr !== 32'h0000_0010) begin bad++; $display("FAIL lw_kseg_addr got=%h exp=00000010", snap_addr); end
      total++; if (snap_size !== 2'd2) begin bad++; $display("FAIL lw_size got=%0d exp=2", snap_size); end
      total++; if ({snap_wr, snap_wstrb} !== 5'b0) begin bad++; $display("FAIL lw_wr_wstrb got=%b exp=0", {snap_wr, snap_wstrb}); end
      total++; if (req_after !== 1'b0) begin bad++; $display("FAIL lw_req_drop got=%b exp=0", req_after); end
      total++; if (early_valid !== 1'b0) begin bad++; $display("FAIL lw_early_valid got=%b exp=0", early_valid); end
      total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL lw_valid_t3 got=%b exp=1", mem_valid); end
      total++; if (mem_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", mem_data); end
      total++; if ({mem_reg, mem_write_regfile, mem_mem_to_regfile, mem_excp} !== {5'd3, 1'b1, 1'b1, 1'b0}) begin
         bad++; $display("FAIL lw_fields got=%h exp=%h", {mem_reg, mem_write_regfile, mem_mem_to_regfile, mem_excp}, {5'd3, 3'b110}); end
      tick();
      total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL lw_valid_pulse got=%b exp=0", mem_valid); end
      total++; if (mem_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data_hold got=%h exp=deadbeef", mem_data); end
   endtask

   task automatic test_load_extend();
      logic [7:0]  ctl_t [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
      logic [31:0] adr_t [4] = '{32'h0000_2003, 32'h0000_2003, 32'h0000_2002, 32'h0000_2000};
      logic [31:0] exp_t [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_1234};
      for (int i = 0; i < 4; i++) begin
         bus_op(ctl_t[i], adr_t[i], 32'h0, 5'd9, 1'b1, 1'b1, 0, 32'h80FF_1234);
         total++; if (mem_valid !== 1'b1 || mem_data !== exp_t[i]) begin
            bad++; $display("FAIL load_ext_%0d got valid=%b data=%h exp valid=1 data=%h", i, mem_valid, mem_data, exp_t[i]); end
         total++; if (snap_addr !== adr_t[i]) begin
            bad++; $display("FAIL load_addr_%0d got=%h exp=%h", i, snap_addr, adr_t[i]); end
      end
      total++; if (snap_size !== 2'd1) begin bad++; $display("FAIL lhu_size got=%0d exp=1", snap_size); end
   endtask

   task automatic test_store_stall();
      bus_op(8'h40, 32'h0000_3002, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 3, 32'h0);
      total++; if (req_first !== 1'b1 || stable !== 1'b1) begin
         bad++; $display("FAIL sh_stall_stable got req=%b stable=%b exp 1 1", req_first, stable); end
      total++; if (rdy_low !== 1'b1) begin bad++; $display("FAIL sh_in_ready_low got=%b exp=1", rdy_low); end
      total++; if (snap_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb got=%b exp=1100", snap_wstrb); end
      total++; if (snap_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", snap_wdata); end
      total++; if (snap_wr !== 1'b1 || snap_size !== 2'd1) begin
         bad++; $display("FAIL sh_wr_size got wr=%b size=%0d exp wr=1 size=1", snap_wr, snap_size); end
      total++; if (early_valid !== 1'b0 || mem_valid !== 1'b1 || mem_data !== 32'h0000_3002) begin
         bad++; $display("FAIL sh_result got early=%b valid=%b data=%h exp 0 1 00003002", early_valid, mem_valid, mem_data); end
      bus_op(8'h20, 32'h0000_3001, 32'h1234_565A, 5'd0, 1'b0, 1'b0, 0, 32'h0);
      total++; if ({snap_wstrb, snap_size, snap_wr} !== {4'b0010, 2'd0, 1'b1}) begin
         bad++; $display("FAIL sb_ctl got wstrb=%b size=%0d wr=%b exp 0010 0 1", snap_wstrb, snap_size, snap_wr); end
      total++; if (snap_wdata !== 32'h5A5A_5A5A) begin bad++; $display("FAIL sb_wdata got=%h exp=5a5a5a5a", snap_wdata); end
      bus_op(8'h80, 32'h0000_3004, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b0, 1, 32'h0);
      total++; if ({snap_wstrb, snap_size, snap_wdata} !== {4'b1111, 2'd2, 32'h0BAD_F00D}) begin
         bad++; $display("FAIL sw_ctl got wstrb=%b size=%0d wdata=%h exp 1111 2 0badf00d", snap_wstrb, snap_size, snap_wdata); end
   endtask

   task automatic test_misaligned();
      drive(8'h10, 32'h0000_1001, 32'h0, 5'd7, 1'b1, 1'b1);
      tick();
      total++; if (data_sram_req !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL adel_no_req got req=%b ready=%b exp 0 1", data_sram_req, in_ready); end
      total++; if (mem_valid !== 1'b1 || mem_excp !== 1'b1 || mem_excode !== 5'h04) begin
         bad++; $display("FAIL adel_excp got valid=%b excp=%b code=%h exp 1 1 04", mem_valid, mem_excp, mem_excode); end
      total++; if (mem_badvaddr !== 32'h0000_1001 || mem_write_regfile !== 1'b0) begin
         bad++; $display("FAIL adel_bad got badv=%h wrf=%b exp 00001001 0", mem_badvaddr, mem_write_regfile); end
      drive(8'h80, 32'h8000_2002, 32'h0, 5'd0, 1'b0, 1'b0);
      tick();
      total++; if (mem_valid !== 1'b1 || mem_excode !== 5'h05 || mem_badvaddr !== 32'h8000_2002) begin
         bad++; $display("FAIL ades got valid=%b code=%h badv=%h exp 1 05 80002002", mem_valid, mem_excode, mem_badvaddr); end
      in_valid = 1'b0;
      tick();
      total++; if (mem_valid !== 1'b0 || data_sram_req !== 1'b0) begin
         bad++; $display("FAIL excp_after got valid=%b req=%b exp 0 0", mem_valid, data_sram_req); end
   endtask

   task automatic test_back_to_back();
      drive(8'h00, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0);
      tick();
      total++; if (mem_valid !== 1'b1 || mem_data !== 32'h0000_1234 || mem_reg !== 5'd5) begin
         bad++; $display("FAIL nonmem got valid=%b data=%h reg=%0d exp 1 00001234 5", mem_valid, mem_data, mem_reg); end
      total++; if (mem_write_regfile !== 1'b1 || mem_excp !== 1'b0) begin
         bad++; $display("FAIL nonmem_flags got wrf=%b excp=%b exp 1 0", mem_write_regfile, mem_excp); end
      for (int i = 0; i < 3; i++) begin
         drive(8'h00, 32'h0000_0100 + i, 32'h0, 5'(10 + i), 1'b1, 1'b0);
         tick();
         total++; if (mem_valid !== 1'b1 || mem_data !== 32'h0000_0100 + i || mem_reg !== 5'(10 + i)) begin
            bad++; $display("FAIL b2b_%0d got valid=%b data=%h reg=%0d exp 1 %h %0d", i, mem_valid, mem_data, mem_reg, 32'h100 + i, 10 + i); end
      end
      drive(8'h11, 32'h0000_0555, 32'h0, 5'd6, 1'b1, 1'b0);
      tick();
      total++; if (mem_valid !== 1'b1 || mem_data !== 32'h0000_0555 || mem_excp !== 1'b0 || data_sram_req !== 1'b0) begin
         bad++; $display("FAIL non_onehot got valid=%b data=%h excp=%b req=%b exp 1 00000555 0 0", mem_valid, mem_data, mem_excp, data_sram_req); end
      in_valid = 1'b0;
      tick();
      total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", mem_valid); end
   endtask

   task automatic test_reset_mid();
      drive(8'h10, 32'h0000_4000, 32'h0, 5'd4, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      data_sram_addr_ok = 1'b1;
      tick();
      data_sram_addr_ok = 1'b0;
      total++; if (in_ready !== 1'b0 || data_sram_req !== 1'b0) begin
         bad++; $display("FAIL mid_in_resp got ready=%b req=%b exp 0 0", in_ready, data_sram_req); end
      reset = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1 || mem_valid !== 1'b0 || mem_data !== 32'h0 || mem_reg !== 5'd0) begin
         bad++; $display("FAIL mid_reset got ready=%b valid=%b data=%h reg=%0d exp 1 0 0 0", in_ready, mem_valid, mem_data, mem_reg); end
      tick();
      reset = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1111_1111;
      tick();
      data_sram_data_ok = 1'b0;
      total++; if (mem_valid !== 1'b0 || data_sram_req !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL stray_data_ok got valid=%b req=%b ready=%b exp 0 0 1", mem_valid, data_sram_req, in_ready); end
      bus_op(8'h10, 32'h0000_5000, 32'h0, 5'd8, 1'b1, 1'b1, 0, 32'hCAFE_F00D);
      total++; if (mem_valid !== 1'b1 || mem_data !== 32'hCAFE_F00D || mem_reg !== 5'd8) begin
         bad++; $display("FAIL post_reset_lw got valid=%b data=%h reg=%0d exp 1 cafef00d 8", mem_valid, mem_data, mem_reg); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_lw_kseg();
      test_load_extend();
      test_store_stall();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM pipeline stage. Consumes the decoded memory-control word, ALU address and store data produced for each instruction by decode/execute.
- Performs loads and stores over an SRAM-like bus, handling bus stalls with a small state machine.
- Drives the registered load/pass-through result (mem_data, mem_reg, mem_write_regfile, mem_mem_to_regfile) back to the decode stage for forwarding and on to writeback.

Parameters:
- KSEG_MAP, 1, when 1 addresses 0x8000_0000..0xBFFF_FFFF are mapped by clearing bits [31:29] before driving data_sram_addr; when 0, pass-through.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present from EXE
- in_ready  out  1  stage can accept; equals (state==IDLE)
- in_mem_control  in  8  one-hot: [0]LB [1]LBU [2]LH [3]LHU [4]LW [5]SB [6]SH [7]SW; 0 = no memory op
- in_addr  in  32  ALU result (address, or pass-through value)
- in_store_data  in  32  rt value for stores
- in_rn  in  5  destination register
- in_write_regfile  in  1  instruction writes regfile
- in_mem_to_regfile  in  1  result comes from memory
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  1 = store
- data_sram_size  out  2  0 byte, 1 half, 2 word
- data_sram_addr  out  32  mapped address
- data_sram_wstrb  out  4  byte enables
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response valid
- data_sram_rdata  in  32  load data
- mem_valid  out  1  result valid this cycle (one-cycle pulse per instruction)
- mem_data  out  32  load result or pass-through in_addr
- mem_reg  out  5  destination register
- mem_write_regfile  out  1  write enable (0 on exception)
- mem_mem_to_regfile  out  1  registered in_mem_to_regfile
- mem_excp  out  1  address-error exception
- mem_excode  out  5  0x04 AdEL, 0x05 AdES
- mem_badvaddr  out  32  faulting unmapped address

Behaviour:
- Reset: all outputs 0, state IDLE, in_ready=1 after reset release.
- States:
  - IDLE: accepts in_valid.
  - REQ: data_sram_req=1 from latched registers.
  - RESP: waiting for data_ok.
- IDLE transitions:
  - in_valid, no mem op, or non-one-hot mem_control: next cycle mem_valid=1, mem_data=in_addr, other fields registered; stay IDLE.
  - Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
    - No bus request.
    - Next cycle mem_valid=1, mem_excp=1, excode AdEL for loads / AdES for stores, mem_badvaddr=in_addr, mem_write_regfile=0.
  - Aligned mem op: latch request; go REQ.
- REQ: hold req and all bus fields stable until addr_ok; on addr_ok go RESP. req drops the cycle after addr_ok.
- RESP: on data_ok go IDLE; same edge registers the result and sets mem_valid=1 next cycle.
  - Loads: aligned/extended rdata.
  - Stores: mem_data = in_addr.
- Bus protocol: data_ok is never in the same cycle as its own addr_ok. data_ok in IDLE/REQ is ignored. At most one outstanding request.
- Minimum mem-op latency: accept T, req T+1, data_ok T+2, mem_valid T+3. Non-mem op: mem_valid T+1.
- in_ready=0 in REQ/RESP; upstream holds in_* stable.
- Store encoding:
  - SB: wstrb = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}, size 0.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}, size 1.
  - SW: wstrb = 4'b1111, size 2.
  - Loads: wstrb = 0.
- Load extraction:
  - Byte lane addr[1:0]; half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW full word.
- mem_data holds its last value when mem_valid=0; forwarding consumers qualify with mem_valid.
- Reset mid-operation: immediately IDLE, req low, mem_valid 0; the bus is reset together with this block.

Decomposition:
- Shared package (mem_pkg):
  - mem_control bit indices and width 8.
  - State encoding IDLE/REQ/RESP.
  - EXC_ADEL=5'h04, EXC_ADES=5'h05.
  - Size codes.
- Sub-module mem_load_align: combinational; rdata, addr[1:0] and load type in, 32-bit extended result out.

Test Plan:
- LW addr 0x8000_0010, addr_ok at T+1, data_ok at T+2, rdata 0xDEADBEEF:
  - Bus sees addr 0x0000_0010, size 2.
  - mem_valid at T+3, mem_data 0xDEADBEEF.
- LB addr ..03, rdata 0x80FF_1234 -> 0xFFFF_FF80. LBU -> 0x0000_0080. LH addr ..02 -> 0xFFFF_80FF.
- SH addr ..02, data 0x0000_ABCD -> wstrb 4'b1100, wdata 0xABCD_ABCD, wr=1, size 1. addr_ok delayed 3 cycles: req and fields stable, in_ready=0 throughout.
- LW addr 0x1001 -> no req, mem_excp=1, excode 0x04, badvaddr 0x1001, mem_write_regfile=0, mem_valid at T+1.
- Non-mem op in_addr 0x1234, rn 5, write_regfile 1 -> next cycle mem_valid=1, mem_data 0x1234, mem_reg 5. Back-to-back non-mem ops give mem_valid every cycle.
- Assert reset in RESP:
  - Outputs 0, state IDLE.
  - Stray data_ok after release ignored.
  - Next LW completes normally.
